// File: rtl/instr_encoder.sv
// instr_encoder: maps control flags back to an opcode, packs an instruction
// word and streams it into instruction memory. Optional: ENC_CHECKSUM_EN.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [8:0]        ctl,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    input  logic [14:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err_illegal,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       checksum
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [8:0] CTL_ALU  = 9'b001000000;
    localparam logic [8:0] CTL_ALUI = 9'b001100000;
    localparam logic [8:0] CTL_LD   = 9'b001000010;
    localparam logic [8:0] CTL_ST   = 9'b010000000;
    localparam logic [8:0] CTL_BEQ  = 9'b000010100;
    localparam logic [8:0] CTL_BGT  = 9'b000001100;
    localparam logic [8:0] CTL_CALL = 9'b000000001;
    localparam logic [8:0] CTL_RET  = 9'b100000000;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  =
        {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  =
        {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic              memWeQ;
    logic [ADDR_W-1:0] ptrQ;
    logic [31:0]       wdataQ;
    logic              errQ;
    logic              fullQ;
    logic [ADDR_W:0]   countQ;

    logic [4:0]        opcode;
    logic              ctlLegal;
    logic              accept;
    logic              acceptLegal;
    logic              acceptIllegal;
    logic              writeDone;
    logic              atLast;

    // Reverse decode: exact flag patterns only, everything else illegal
    always_comb begin
        opcode   = 5'd0;
        ctlLegal = 1'b1;
        case (ctl)
            CTL_ALU:  opcode = 5'd0;
            CTL_ALUI: opcode = 5'd1;
            CTL_LD:   opcode = 5'd2;
            CTL_ST:   opcode = 5'd3;
            CTL_BEQ:  opcode = 5'd4;
            CTL_BGT:  opcode = 5'd5;
            CTL_CALL: opcode = 5'd6;
            CTL_RET:  opcode = 5'd7;
            default:  ctlLegal = 1'b0;
        endcase
    end

    // Handshake and write-completion qualifiers
    always_comb begin
        req_ready     = (state == IDLE) && !fullQ;
        accept        = req_valid && req_ready;
        acceptLegal   = accept && ctlLegal;
        acceptIllegal = accept && !ctlLegal;
        writeDone     = (state == WRITE) && mem_ready;
        atLast        = (ptrQ == PTR_LAST);
    end

    // Control FSM; clear wins over every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptLegal) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state <= atLast ? FULL : IDLE;
                    end
                end
                FULL: begin
                    state <= FULL;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write strobe, high for the whole WRITE phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memWeQ <= 1'b0;
        end else if (clear) begin
            memWeQ <= 1'b0;
        end else if (acceptLegal) begin
            memWeQ <= 1'b1;
        end else if (writeDone) begin
            memWeQ <= 1'b0;
        end
    end

    // Packed word is captured at the handshake and held through stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdataQ <= 32'd0;
        end else if (!clear && acceptLegal) begin
            wdataQ <= {opcode, rd, rs1, rs2, imm};
        end
    end

    // Write pointer; parks on the last address instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptrQ <= '0;
        end else if (clear) begin
            ptrQ <= '0;
        end else if (writeDone && !atLast) begin
            ptrQ <= ptrQ + PTR_ONE;
        end
    end

    // Completed-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= '0;
        end else if (clear) begin
            countQ <= '0;
        end else if (writeDone) begin
            countQ <= countQ + CNT_ONE;
        end
    end

    // Full flag raised when the last address is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fullQ <= 1'b0;
        end else if (clear) begin
            fullQ <= 1'b0;
        end else if (writeDone && atLast) begin
            fullQ <= 1'b1;
        end
    end

    // Sticky illegal-request flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errQ <= 1'b0;
        end else if (clear) begin
            errQ <= 1'b0;
        end else if (acceptIllegal) begin
            errQ <= 1'b1;
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] sumQ;

    // Running XOR over every word memory accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sumQ <= 32'd0;
        end else if (clear) begin
            sumQ <= 32'd0;
        end else if (memWeQ && mem_ready) begin
            sumQ <= sumQ ^ wdataQ;
        end
    end

    assign checksum = sumQ;
`else
    assign checksum = 32'd0;
`endif

    assign mem_we      = memWeQ;
    assign mem_addr    = ptrQ;
    assign mem_wdata   = wdataQ;
    assign err_illegal = errQ;
    assign full        = fullQ;
    assign count       = countQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder (8-bit and 2-bit
// address builds share stimulus).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        reqValid = 1'b0;
    logic [8:0]  ctl = '0;
    logic [3:0]  rd = '0;
    logic [3:0]  rs1 = '0;
    logic [3:0]  rs2 = '0;
    logic [14:0] imm = '0;
    logic        memReady = 1'b1;

    logic        reqReady, memWe, errIllegal, full;
    logic [7:0]  memAddr;
    logic [31:0] memWdata, checksum;
    logic [8:0]  count;

    logic        reqReady2, memWe2, errIllegal2, full2;
    logic [1:0]  memAddr2;
    logic [31:0] memWdata2, checksum2;
    logic [2:0]  count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(reqValid), .req_ready(reqReady),
        .ctl(ctl), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_ready(memReady), .err_illegal(errIllegal),
        .full(full), .count(count), .checksum(checksum)
    );

    instr_encoder #(.ADDR_W(2)) dutSmall (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(reqValid), .req_ready(reqReady2),
        .ctl(ctl), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(memWe2), .mem_addr(memAddr2), .mem_wdata(memWdata2),
        .mem_ready(memReady), .err_illegal(errIllegal2),
        .full(full2), .count(count2), .checksum(checksum2)
    );

    typedef struct {
        logic [8:0]  c;
        logic [3:0]  d;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [14:0] i;
        logic        legal;
        logic [4:0]  op;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [4:0] op,
        input logic [3:0] d, input logic [3:0] a,
        input logic [3:0] b, input logic [14:0] i);
        return {op, d, a, b, i};
    endfunction

    // Offer one request; returns at #1 after the handshake edge
    task automatic issue(input logic [8:0] c, input logic [3:0] d,
        input logic [3:0] a, input logic [3:0] b, input logic [14:0] i);
        int n;
        ctl = c; rd = d; rs1 = a; rs2 = b; imm = i;
        reqValid = 1'b1;
        n = 0;
        while (!reqReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    logic [7:0]  expAddr;
    logic [8:0]  expCount;
    logic        expErr;
    logic [31:0] expSum;
    logic [31:0] w;

    initial begin
        tbl[0]  = '{9'b001000000, 4'd1, 4'd2, 4'd3, 15'd5,     1'b1, 5'd0};
        tbl[1]  = '{9'b001100000, 4'd4, 4'd5, 4'd0, 15'h7fff,  1'b1, 5'd1};
        tbl[2]  = '{9'b001000010, 4'd15, 4'd14, 4'd13, 15'd0,  1'b1, 5'd2};
        tbl[3]  = '{9'b010000000, 4'd0, 4'd9, 4'd8, 15'h1234,  1'b1, 5'd3};
        tbl[4]  = '{9'b000010100, 4'd0, 4'd1, 4'd1, 15'h0040,  1'b1, 5'd4};
        tbl[5]  = '{9'b000001100, 4'd0, 4'd2, 4'd3, 15'h4000,  1'b1, 5'd5};
        tbl[6]  = '{9'b000000001, 4'd0, 4'd0, 4'd0, 15'h0100,  1'b1, 5'd6};
        tbl[7]  = '{9'b100000000, 4'd0, 4'd0, 4'd0, 15'd0,     1'b1, 5'd7};
        tbl[8]  = '{9'b000011000, 4'd1, 4'd1, 4'd1, 15'd1,     1'b0, 5'd0};
        tbl[9]  = '{9'b000000000, 4'd2, 4'd2, 4'd2, 15'd2,     1'b0, 5'd0};
        tbl[10] = '{9'b000000001, 4'd0, 4'd0, 4'd0, 15'h0abc,  1'b1, 5'd6};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, reqReady}, 32'd1);
        chk("rst_we", {31'd0, memWe}, 32'd0);
        chk("rst_addr", {24'd0, memAddr}, 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        chk("rst_err", {31'd0, errIllegal}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {23'd0, count}, 32'd0);
        chk("rst_sum", checksum, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        expAddr = 0; expCount = 0; expErr = 0; expSum = 0;
        for (int k = 0; k < 11; k++) begin
            issue(tbl[k].c, tbl[k].d, tbl[k].a, tbl[k].b, tbl[k].i);
            if (tbl[k].legal) begin
                w = pack(tbl[k].op, tbl[k].d, tbl[k].a, tbl[k].b,
                         tbl[k].i);
                chk($sformatf("v%0d_we", k), {31'd0, memWe}, 32'd1);
                chk($sformatf("v%0d_ready", k), {31'd0, reqReady}, 32'd0);
                chk($sformatf("v%0d_addr", k), {24'd0, memAddr},
                    {24'd0, expAddr});
                chk($sformatf("v%0d_wdata", k), memWdata, w);
                @(posedge clk); #1;
                expAddr++;
                expCount++;
`ifdef ENC_CHECKSUM_EN
                expSum ^= w;
`endif
                chk($sformatf("v%0d_wedrop", k), {31'd0, memWe}, 32'd0);
                chk($sformatf("v%0d_rdy2", k), {31'd0, reqReady}, 32'd1);
                chk($sformatf("v%0d_count", k), {23'd0, count},
                    {23'd0, expCount});
                chk($sformatf("v%0d_sum", k), checksum, expSum);
            end else begin
                expErr = 1'b1;
                chk($sformatf("v%0d_nowe", k), {31'd0, memWe}, 32'd0);
                chk($sformatf("v%0d_count", k), {23'd0, count},
                    {23'd0, expCount});
            end
            chk($sformatf("v%0d_err", k), {31'd0, errIllegal},
                {31'd0, expErr});
        end

        // Stalled write: everything holds until memory accepts
        memReady = 1'b0;
        issue(9'b010000000, 4'd3, 4'd4, 4'd5, 15'h0055);
        w = pack(5'd3, 4'd3, 4'd4, 4'd5, 15'h0055);
        for (int k = 0; k < 5; k++) begin
            chk("stall_we", {31'd0, memWe}, 32'd1);
            chk("stall_addr", {24'd0, memAddr}, {24'd0, expAddr});
            chk("stall_wdata", memWdata, w);
            chk("stall_ready", {31'd0, reqReady}, 32'd0);
            @(posedge clk); #1;
        end
        chk("stall_count", {23'd0, count}, {23'd0, expCount});
        memReady = 1'b1;
        @(posedge clk); #1;
        expCount++;
        chk("stall_done_we", {31'd0, memWe}, 32'd0);
        chk("stall_done_cnt", {23'd0, count}, {23'd0, expCount});

        // Fill the 4-word instance, then confirm it refuses more
        pulseClear();
        chk("clr_count", {23'd0, count}, 32'd0);
        chk("clr_err", {31'd0, errIllegal}, 32'd0);
        chk("clr_addr", {24'd0, memAddr}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            issue(9'b001000000, 4'(k), 4'd0, 4'd0, 15'(k));
            chk($sformatf("s%0d_we", k), {31'd0, memWe2}, 32'd1);
            chk($sformatf("s%0d_addr", k), {30'd0, memAddr2}, k);
            @(posedge clk); #1;
        end
        chk("small_full", {31'd0, full2}, 32'd1);
        chk("small_ready", {31'd0, reqReady2}, 32'd0);
        chk("small_count", {29'd0, count2}, 32'd4);
        ctl = 9'b001000000;
        reqValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("small_5th_we", {31'd0, memWe2}, 32'd0);
            chk("small_5th_cnt", {29'd0, count2}, 32'd4);
        end
        reqValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pulseClear();
        chk("small_clr_full", {31'd0, full2}, 32'd0);
        chk("small_clr_cnt", {29'd0, count2}, 32'd0);
        chk("small_clr_ready", {31'd0, reqReady2}, 32'd1);
        issue(9'b000000001, 4'd0, 4'd0, 4'd0, 15'd9);
        chk("small_rew_we", {31'd0, memWe2}, 32'd1);
        chk("small_rew_addr", {30'd0, memAddr2}, 32'd0);
        @(posedge clk); #1;

        // Checksum over two known words, then reset mid-write
        pulseClear();
        chk("sum_clr", checksum, 32'd0);
        issue(9'b001000000, 4'd2, 4'd4, 4'd6, 15'd5);
        chk("sumw1", memWdata, 32'h01230005);
        @(posedge clk); #1;
        issue(9'b001100000, 4'd0, 4'd0, 4'd0, 15'd1);
        chk("sumw2", memWdata, 32'h08000001);
        @(posedge clk); #1;
`ifdef ENC_CHECKSUM_EN
        chk("sum_val", checksum, 32'h09230004);
`else
        chk("sum_val", checksum, 32'h00000000);
`endif
        memReady = 1'b0;
        issue(9'b100000000, 4'd1, 4'd1, 4'd1, 15'd1);
        chk("mid_we", {31'd0, memWe}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, memWe}, 32'd0);
        chk("arst_sum", checksum, 32'd0);
        chk("arst_count", {23'd0, count}, 32'd0);
        chk("arst_addr", {24'd0, memAddr}, 32'd0);
        chk("arst_wdata", memWdata, 32'd0);
        chk("arst_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        memReady = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_we", {31'd0, memWe}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
